rr_sel_arbiter: RTL and testbench

- Two-channel round-robin arbiter with a registered output stage.
- Sits directly upstream of the team's 2:1 select mux: it decides which of two valid/ready source channels is forwarded each cycle.
- It drives the `sel` line (0 = channel 0, 1 = channel 1) and presents the winning data word.
- Provides backpressure to both sources and a wrapping transfer counter for debug.

---
 rtl/rr_sel_arbiter_if.sv | 28 ++
 rtl/rr_sel_arbiter.sv | 87 ++++++++
 tb/tb_rr_sel_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_sel_arbiter_if.sv
// Channel bundle for rr_sel_arbiter: two valid/ready sources and one registered output.
// The slave modport is the arbiter's view, and the master modport is the environment's view.
interface rr_sel_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             sel;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_cnt;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, sel, xfer_cnt
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, sel, xfer_cnt
  );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Two-channel round-robin arbiter with a one-word registered output stage that drives
// the select line of the downstream 2:1 mux, plus a wrapping accepted-word counter.
module rr_sel_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  rr_sel_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic can_load;
  logic grant_vld;
  logic grant_ch;
  logic accept;

  // A lone valid channel always wins; under contention the channel not served last wins.
  always_comb begin
    grant_vld = bus.in0_valid | bus.in1_valid;
    grant_ch  = 1'b0;
    if (bus.in0_valid && bus.in1_valid) begin
      grant_ch = ~last_q;
    end else if (bus.in1_valid) begin
      grant_ch = 1'b1;
    end
  end

  // Reset gates can_load so that no source sees a handshake while rst_n is low.
  assign can_load = rst_n && ((state_q == StEmpty) || bus.out_ready);
  assign accept   = can_load && grant_vld;

  assign bus.in0_ready = can_load && grant_vld && !grant_ch;
  assign bus.in1_ready = can_load && grant_vld && grant_ch;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (bus.out_ready && !accept) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
    if (accept) begin
      data_d = grant_ch ? bus.in1_data : bus.in0_data;
      sel_d  = grant_ch;
      last_d = grant_ch;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed testbench for rr_sel_arbiter. Inputs are driven and outputs are sampled
// a few time units after the rising edge.
module tb_rr_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_sel_arbiter_if #(.WIDTH(8), .CNT_W(8)) bus ();

  rr_sel_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data  = 8'h00;
    bus.in1_data  = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.in0_data  = 8'h11;
    bus.in1_data  = 8'h22;
    bus.out_ready = 1'b1;
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h want 0", bus.out_data); end
    checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %0h want 0", bus.sel); end
    checks++; if (bus.xfer_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %0h want 0", bus.xfer_cnt); end
    checks++; if (bus.in0_ready !== 1'b0) begin errors++; $display("FAIL reset_in0_ready got %0h want 0", bus.in0_ready); end
    checks++; if (bus.in1_ready !== 1'b0) begin errors++; $display("FAIL reset_in1_ready got %0h want 0", bus.in1_ready); end
    tick();
  endtask

  task automatic test_single;
    bus.in1_valid = 1'b0;
    bus.in0_valid = 1'b1;
    bus.in0_data  = 8'h11;
    bus.out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    settle();
    checks++; if (bus.in0_ready !== 1'b1) begin errors++; $display("FAIL single_in0_ready got %0h want 1", bus.in0_ready); end
    checks++; if (bus.in1_ready !== 1'b0) begin errors++; $display("FAIL single_in1_ready got %0h want 0", bus.in1_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0h want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL single_out_data got %0h want 11", bus.out_data); end
    checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL single_sel got %0h want 0", bus.sel); end
    checks++; if (bus.xfer_cnt !== 8'h01) begin errors++; $display("FAIL single_cnt got %0h want 1", bus.xfer_cnt); end
    bus.in0_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %0h want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL drain_out_data got %0h want 11", bus.out_data); end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_data;
    do_reset();
    bus.in0_data  = 8'hA0;
    bus.in1_data  = 8'hB1;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_data = (i % 2 == 0) ? 8'hA0 : 8'hB1;
      settle();
      checks++; if (bus.in0_ready !== (i % 2 == 0)) begin errors++; $display("FAIL rr_in0_ready[%0d] got %0h want %0h", i, bus.in0_ready, (i % 2 == 0)); end
      tick();
      checks++; if (bus.out_data !== exp_data) begin errors++; $display("FAIL rr_data[%0d] got %0h want %0h", i, bus.out_data, exp_data); end
      checks++; if (bus.sel !== (i % 2 == 1)) begin errors++; $display("FAIL rr_sel[%0d] got %0h want %0h", i, bus.sel, (i % 2 == 1)); end
      checks++; if (bus.xfer_cnt !== 8'(i + 1)) begin errors++; $display("FAIL rr_cnt[%0d] got %0h want %0h", i, bus.xfer_cnt, i + 1); end
    end
  endtask

  task automatic test_stall;
    do_reset();
    bus.in0_data  = 8'hA0;
    bus.in1_data  = 8'hB1;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin errors++; $display("FAIL stall_readys[%0d] got %0b want 00", i, {bus.in0_ready, bus.in1_ready}); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0h want 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== 8'hA0) begin errors++; $display("FAIL stall_data[%0d] got %0h want a0", i, bus.out_data); end
      checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL stall_sel[%0d] got %0h want 0", i, bus.sel); end
      checks++; if (bus.xfer_cnt !== 8'h01) begin errors++; $display("FAIL stall_cnt[%0d] got %0h want 1", i, bus.xfer_cnt); end
    end
    bus.out_ready = 1'b1;
    settle();
    checks++; if (bus.in1_ready !== 1'b1) begin errors++; $display("FAIL unstall_in1_ready got %0h want 1", bus.in1_ready); end
    tick();
    checks++; if (bus.out_data !== 8'hB1) begin errors++; $display("FAIL unstall_data got %0h want b1", bus.out_data); end
    checks++; if (bus.sel !== 1'b1) begin errors++; $display("FAIL unstall_sel got %0h want 1", bus.sel); end
    checks++; if (bus.xfer_cnt !== 8'h02) begin errors++; $display("FAIL unstall_cnt got %0h want 2", bus.xfer_cnt); end
  endtask

  // Continues from test_stall, where channel 1 was served last.
  task automatic test_single_channel;
    bus.in0_valid = 1'b0;
    bus.in1_data  = 8'h5C;
    bus.in1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++; if (bus.in1_ready !== 1'b1) begin errors++; $display("FAIL ch1_ready[%0d] got %0h want 1", i, bus.in1_ready); end
      tick();
      checks++; if (bus.out_data !== 8'h5C) begin errors++; $display("FAIL ch1_data[%0d] got %0h want 5c", i, bus.out_data); end
      checks++; if (bus.sel !== 1'b1) begin errors++; $display("FAIL ch1_sel[%0d] got %0h want 1", i, bus.sel); end
      checks++; if (bus.xfer_cnt !== 8'(3 + i)) begin errors++; $display("FAIL ch1_cnt[%0d] got %0h want %0h", i, bus.xfer_cnt, 3 + i); end
    end
    bus.in0_data  = 8'hA0;
    bus.in0_valid = 1'b1;
    settle();
    checks++; if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin errors++; $display("FAIL both_readys got %0b want 10", {bus.in0_ready, bus.in1_ready}); end
    tick();
    checks++; if (bus.out_data !== 8'hA0) begin errors++; $display("FAIL both_data got %0h want a0", bus.out_data); end
    checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL both_sel got %0h want 0", bus.sel); end
    checks++; if (bus.xfer_cnt !== 8'h07) begin errors++; $display("FAIL both_cnt got %0h want 7", bus.xfer_cnt); end
  endtask

  task automatic test_wrap;
    do_reset();
    bus.in0_data  = 8'h3C;
    bus.in0_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (255) tick();
    checks++; if (bus.xfer_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_cnt_255 got %0h want ff", bus.xfer_cnt); end
    tick();
    checks++; if (bus.xfer_cnt !== 8'h00) begin errors++; $display("FAIL wrap_cnt_256 got %0h want 0", bus.xfer_cnt); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0h want 1", bus.out_valid); end
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.in0_data  = 8'h77;
    bus.in0_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in1_data  = 8'hB1;
    bus.in1_valid = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL held_valid got %0h want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h77) begin errors++; $display("FAIL held_data got %0h want 77", bus.out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL arst_data got %0h want 0", bus.out_data); end
    checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL arst_sel got %0h want 0", bus.sel); end
    checks++; if (bus.xfer_cnt !== 8'h00) begin errors++; $display("FAIL arst_cnt got %0h want 0", bus.xfer_cnt); end
    checks++; if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin errors++; $display("FAIL arst_readys got %0b want 00", {bus.in0_ready, bus.in1_ready}); end
    tick();
    rst_n = 1'b1;
    bus.in0_data  = 8'hA0;
    bus.out_ready = 1'b1;
    settle();
    checks++; if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin errors++; $display("FAIL post_rst_readys got %0b want 10", {bus.in0_ready, bus.in1_ready}); end
    tick();
    checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL post_rst_sel got %0h want 0", bus.sel); end
    checks++; if (bus.out_data !== 8'hA0) begin errors++; $display("FAIL post_rst_data got %0h want a0", bus.out_data); end
    checks++; if (bus.xfer_cnt !== 8'h01) begin errors++; $display("FAIL post_rst_cnt got %0h want 1", bus.xfer_cnt); end
  endtask

  initial begin
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data  = 8'h00;
    bus.in1_data  = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_single_channel();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
